// File: rtl/frame_sequencer_pkg.sv
// hough_pkg: shared state encoding and default geometry for the frame sequencer
package hough_pkg;
   typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} seq_state_t;
   localparam int COLS_DEFAULT = 256;
   localparam int INIT_CYCLES_DEFAULT = 3;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: last-stage pipeline handshake plus column sink write port
interface frame_sequencer_if #(parameter int AW = 8);
   logic pipe_init, pipe_req, pipe_rdy, pipe_last, sink_ready, col_we;
   logic [AW-1:0] col_addr;
   modport master(output pipe_init, pipe_req, col_we, col_addr, input pipe_rdy, pipe_last, sink_ready);
   modport slave(input pipe_init, pipe_req, col_we, col_addr, output pipe_rdy, pipe_last, sink_ready);
endinterface

// File: rtl/frame_sequencer_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(parameter int W = 8) (
   input  logic         clock,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] q
);
   // clear wins over counting; counting stops at the top value
   always_ff @(posedge clock)
      if (clear) q <= '0;
      else if (enable && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: flushes the column pipeline, consumes its columns into the sink and tracks frame statistics
module frame_sequencer import hough_pkg::*; #(
   parameter int COLS = COLS_DEFAULT,
   parameter int AW = $clog2(COLS),
   parameter int INIT_CYCLES = INIT_CYCLES_DEFAULT,
   parameter int TIMEOUT = 1024,
   parameter int CW = 24
) (
   input  logic               clock,
   input  logic               init,
   input  logic               start,
   input  logic               abort,
   input  logic               continuous,
   frame_sequencer_if.master  bus,
   output logic               busy,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [CW-1:0]      frame_cycles,
   output logic               col_err,
   output logic               timeout
);
   localparam int SW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(INIT_CYCLES + 1);
   seq_state_t r_state;
   logic [AW-1:0] r_col_idx;
   logic [FW-1:0] r_flush_cnt;
   logic r_gap;
   logic [SW-1:0] w_stall;
   logic [CW-1:0] w_cycles;
   logic w_run, w_req, w_accept, w_last_col, w_end, w_stall_out, w_to_flush;
   assign w_run = r_state == RUN;
   assign w_req = w_run & bus.sink_ready & ~r_gap;
   assign w_accept = w_req & bus.pipe_rdy;
   assign w_last_col = r_col_idx == AW'(COLS - 1);
   assign w_end = w_accept & (bus.pipe_last | w_last_col);
   assign w_stall_out = w_run & ~w_accept & (w_stall == SW'(TIMEOUT - 1));
   assign w_to_flush = ~abort & ((r_state == IDLE & start) | (r_state == DONE & continuous));
   assign bus.pipe_init = r_state == FLUSH;
   assign bus.pipe_req = w_req;
   assign bus.col_we = w_accept;
   assign bus.col_addr = r_col_idx;
   assign busy = r_state != IDLE;
   assign frame_done = (r_state == DONE) & ~abort;
   sat_counter #(.W(SW)) u_stall (
      .clock(clock), .clear(init | w_to_flush | w_accept), .enable(w_run), .q(w_stall)
   );
   sat_counter #(.W(CW)) u_cycles (
      .clock(clock), .clear(init | w_to_flush), .enable(bus.pipe_init | w_run), .q(w_cycles)
   );
   // frame FSM with column index, accept spacing and per-frame statistics
   always_ff @(posedge clock) begin
      if (init) begin
         r_state <= IDLE;
         r_col_idx <= '0;
         r_flush_cnt <= '0;
         r_gap <= 1'b0;
         frame_count <= '0;
         frame_cycles <= '0;
         col_err <= 1'b0;
         timeout <= 1'b0;
      end else begin
         r_gap <= w_accept;
         if (frame_done) begin
            frame_count <= frame_count + 1'b1;
            frame_cycles <= w_cycles;
         end
         if (w_to_flush) begin
            r_state <= FLUSH;
            r_flush_cnt <= '0;
            r_col_idx <= '0;
            r_gap <= 1'b0;
            col_err <= 1'b0;
            timeout <= 1'b0;
         end else if (abort) r_state <= IDLE;
         else if (r_state == FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_flush_cnt == FW'(INIT_CYCLES - 1)) r_state <= RUN;
         end else if (w_run) begin
            if (w_accept) r_col_idx <= r_col_idx + 1'b1;
            if (w_end) begin
               r_state <= DONE;
               col_err <= ~(bus.pipe_last & w_last_col);
            end else if (w_stall_out) begin
               r_state <= IDLE;
               timeout <= 1'b1;
            end
         end else if (r_state == DONE) r_state <= IDLE;
      end
   end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed frame scenarios for frame_sequencer with COLS=4, INIT_CYCLES=3, TIMEOUT=8
module tb_frame_sequencer;
   logic clock = 0, init = 1, start = 0, abort = 0, continuous = 0;
   logic busy, frame_done, col_err, timeout;
   logic [15:0] frame_count;
   logic [23:0] frame_cycles;
   int tests = 0, fails = 0;
   int n_init, n_we, n_done, bad_addr, we_low, t_done, t_first, t_idle;
   frame_sequencer_if #(.AW(2)) bus();
   frame_sequencer #(.COLS(4), .INIT_CYCLES(3), .TIMEOUT(8), .CW(24)) dut (
      .clock(clock), .init(init), .start(start), .abort(abort), .continuous(continuous),
      .bus(bus), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
      .frame_cycles(frame_cycles), .col_err(col_err), .timeout(timeout)
   );
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // c counts falling edges after the edge that sampled start; c=1 is the first FLUSH cycle
   task automatic run_frame(input int last_at, input bit bp, input int cycles, input int stop_cont);
      n_init = 0; n_we = 0; n_done = 0; bad_addr = 0; we_low = 0;
      t_done = -1; t_first = -1; t_idle = -1;
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clock);
         start = 0;
         if (c == stop_cont) continuous = 0;
         bus.sink_ready = bp ? ((c % 3) == 1) : 1'b1;
         bus.pipe_last = (last_at > 0) && ((n_we % last_at) == last_at - 1);
         #1;
         if (bus.pipe_init) n_init++;
         if (bus.col_we) begin
            if (t_first < 0) t_first = c;
            if (bus.col_addr !== 2'(n_we)) bad_addr++;
            if (!bus.sink_ready) we_low++;
            n_we++;
         end
         if (frame_done) begin
            n_done++;
            if (t_done < 0) t_done = c;
         end
         if (!busy && t_idle < 0) t_idle = c;
      end
   endtask

   initial begin
      bus.sink_ready = 1; bus.pipe_rdy = 1; bus.pipe_last = 0;
      @(negedge clock); @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_pipe_init", bus.pipe_init, 0);
      chk("rst_pipe_req", bus.pipe_req, 0);
      chk("rst_col_we", bus.col_we, 0);
      chk("rst_col_addr", bus.col_addr, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_frame_cycles", frame_cycles, 0);
      chk("rst_col_err", col_err, 0);
      chk("rst_timeout", timeout, 0);
      init = 0;
      // nominal frame
      @(negedge clock); start = 1;
      run_frame(4, 0, 14, 0);
      chk("nom_init_cycles", n_init, 3);
      chk("nom_first_we", t_first, 4);
      chk("nom_we_count", n_we, 4);
      chk("nom_addr_order", bad_addr, 0);
      chk("nom_done_pulses", n_done, 1);
      chk("nom_done_time", t_done, 11);
      chk("nom_idle_time", t_idle, 12);
      chk("nom_frame_count", frame_count, 1);
      chk("nom_frame_cycles", frame_cycles, 10);
      chk("nom_col_err", col_err, 0);
      // backpressure: sink_ready 1,0,0 repeating
      @(negedge clock); start = 1;
      run_frame(4, 1, 18, 0);
      chk("bp_we_while_low", we_low, 0);
      chk("bp_we_count", n_we, 4);
      chk("bp_addr_order", bad_addr, 0);
      chk("bp_done_time", t_done, 14);
      chk("bp_frame_count", frame_count, 2);
      chk("bp_frame_cycles", frame_cycles, 13);
      chk("bp_col_err", col_err, 0);
      // early last on third column
      @(negedge clock); start = 1;
      run_frame(3, 0, 12, 0);
      chk("early_we_count", n_we, 3);
      chk("early_done_time", t_done, 9);
      chk("early_col_err", col_err, 1);
      chk("early_frame_count", frame_count, 3);
      chk("early_frame_cycles", frame_cycles, 8);
      // late last: no pipe_last at all
      @(negedge clock); start = 1;
      run_frame(0, 0, 13, 0);
      chk("late_we_count", n_we, 4);
      chk("late_done_time", t_done, 11);
      chk("late_col_err", col_err, 1);
      chk("late_frame_count", frame_count, 4);
      // stall watchdog
      bus.pipe_rdy = 0;
      @(negedge clock); start = 1;
      run_frame(0, 0, 14, 0);
      chk("stall_idle_time", t_idle, 12);
      chk("stall_timeout", timeout, 1);
      chk("stall_done_pulses", n_done, 0);
      chk("stall_frame_count", frame_count, 4);
      chk("stall_col_err_cleared", col_err, 0);
      chk("stall_we_count", n_we, 0);
      bus.pipe_rdy = 1;
      // abort together with start during an accept cycle
      @(negedge clock); start = 1;
      run_frame(0, 0, 5, 0);
      chk("abort_pre_timeout_cleared", timeout, 0);
      chk("abort_pre_busy", busy, 1);
      @(negedge clock); abort = 1; start = 1;
      #1 chk("abort_accept_cycle_req", bus.pipe_req, 1);
      @(negedge clock); abort = 0; start = 0;
      chk("abort_busy", busy, 0);
      chk("abort_pipe_init", bus.pipe_init, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_frame_count", frame_count, 4);
      // continuous mode, three frames back to back
      @(negedge clock); start = 1; continuous = 1;
      run_frame(4, 0, 36, 30);
      chk("cont_init_cycles", n_init, 9);
      chk("cont_we_count", n_we, 12);
      chk("cont_addr_order", bad_addr, 0);
      chk("cont_done_pulses", n_done, 3);
      chk("cont_first_done", t_done, 11);
      chk("cont_idle_time", t_idle, 34);
      chk("cont_frame_count", frame_count, 7);
      chk("cont_frame_cycles", frame_cycles, 10);
      // init mid-frame
      @(negedge clock); start = 1;
      run_frame(4, 0, 6, 0);
      chk("mid_busy_before", busy, 1);
      @(negedge clock); init = 1;
      @(negedge clock);
      chk("mid_busy", busy, 0);
      chk("mid_pipe_init", bus.pipe_init, 0);
      chk("mid_pipe_req", bus.pipe_req, 0);
      chk("mid_col_we", bus.col_we, 0);
      chk("mid_col_addr", bus.col_addr, 0);
      chk("mid_frame_done", frame_done, 0);
      chk("mid_frame_count", frame_count, 0);
      chk("mid_frame_cycles", frame_cycles, 0);
      chk("mid_col_err", col_err, 0);
      chk("mid_timeout", timeout, 0);
      init = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
